// File: rtl/mult_fast_pkg.sv
// Shared types and helpers for the digit-serial N x N multiplier.
// Digit-index search is bit-based so it folds to constants per CHUNK.
package mult_fast_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CHUNK = 8;
    localparam int D         = DEF_WIDTH / DEF_CHUNK;
    localparam int MSD_MAX_W = 256;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    // Index of the highest nonzero chunk-wide digit; 0 for a zero operand.
    function automatic int msd_index(input logic [MSD_MAX_W-1:0] x, input int chunk);
        int idx;
        idx = 0;
        for (int k = 0; k < MSD_MAX_W; k++) begin
            if (x[k]) idx = k / chunk;
        end
        return idx;
    endfunction

endpackage

// File: rtl/mult_nxn_fast_fsm.sv
// Sequencer for the digit-serial multiplier: state, digit counters i/j,
// early-termination compare against na/nb, and datapath strobes.
//
// state | meaning
// IDLE  | waiting for start; done pulses here for one cycle after FIX
// RUN   | one digit pair (i,j) multiplied and accumulated per cycle
// FIX   | optional two's-complement negate of the accumulated magnitude
module mult_nxn_fast_fsm
    import mult_fast_pkg::*;
#(
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          zero_op,
    input  logic          neg_in,
    input  logic [CW-1:0] na_in,
    input  logic [CW-1:0] nb_in,
    output logic          clr_prod,
    output logic          upd_prod,
    output logic          neg_prod,
    output logic [CW-1:0] a_sel,
    output logic [CW-1:0] b_sel,
    output logic [CW:0]   shift_sel,
    output logic          busy,
    output logic          done
);

    state_t        state;
    logic [CW-1:0] na;
    logic [CW-1:0] nb;
    logic          neg;

    assign clr_prod  = (state == IDLE) && start;
    assign upd_prod  = (state == RUN);
    assign neg_prod  = (state == FIX) && neg;
    assign shift_sel = {1'b0, a_sel} + {1'b0, b_sel};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            na    <= '0;
            nb    <= '0;
            neg   <= 1'b0;
            a_sel <= '0;
            b_sel <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        na    <= na_in;
                        nb    <= nb_in;
                        neg   <= neg_in;
                        a_sel <= '0;
                        b_sel <= '0;
                        busy  <= 1'b1;
                        state <= zero_op ? FIX : RUN;
                    end
                end
                RUN: begin
                    if ((a_sel == na) && (b_sel == nb)) begin
                        state <= FIX;
                    end else if (b_sel == nb) begin
                        b_sel <= '0;
                        a_sel <= a_sel + 1'b1;
                    end else begin
                        b_sel <= b_sel + 1'b1;
                    end
                end
                FIX: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/mult_nxn_fast.sv
// Digit-serial N x N multiplier with early termination on small operands
// and run-time signed/unsigned mode. Datapath lives here; sequencing in the fsm.
module mult_nxn_fast
    import mult_fast_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int NDIG = WIDTH / CHUNK;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int PW   = 2 * WIDTH;
    localparam int SW   = $clog2(PW);
    localparam int PPW  = 2 * CHUNK;

    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH-1:0] ma, mb;
    logic             neg_in, zero_op;
    logic [CW-1:0]    na_in, nb_in;
    logic [CW-1:0]    a_sel, b_sel;
    logic [CW:0]      shift_sel;
    logic             clr_prod, upd_prod, neg_prod;
    logic [CHUNK-1:0] dig_a, dig_b;
    logic [PPW-1:0]   pp;
    logic [SW-1:0]    shamt;
    logic [PW-1:0]    partial;

    // The most negative value negates to itself, which is its correct unsigned magnitude.
    assign abs_a   = (signed_mode && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
    assign abs_b   = (signed_mode && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
    assign neg_in  = signed_mode && (a[WIDTH-1] ^ b[WIDTH-1]);
    assign zero_op = (abs_a == '0) || (abs_b == '0);
    assign na_in   = CW'(msd_index(MSD_MAX_W'(abs_a), CHUNK));
    assign nb_in   = CW'(msd_index(MSD_MAX_W'(abs_b), CHUNK));

    assign dig_a   = ma[a_sel*CHUNK +: CHUNK];
    assign dig_b   = mb[b_sel*CHUNK +: CHUNK];
    assign pp      = PPW'(dig_a) * PPW'(dig_b);
    assign shamt   = SW'(shift_sel) * SW'(CHUNK);
    assign partial = PW'(pp) << shamt;

    mult_nxn_fast_fsm #(
        .CW (CW)
    ) u_fsm (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .zero_op   (zero_op),
        .neg_in    (neg_in),
        .na_in     (na_in),
        .nb_in     (nb_in),
        .clr_prod  (clr_prod),
        .upd_prod  (upd_prod),
        .neg_prod  (neg_prod),
        .a_sel     (a_sel),
        .b_sel     (b_sel),
        .shift_sel (shift_sel),
        .busy      (busy),
        .done      (done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ma      <= '0;
            mb      <= '0;
            product <= '0;
        end else if (clr_prod) begin
            ma      <= abs_a;
            mb      <= abs_b;
            product <= '0;
        end else if (upd_prod) begin
            product <= product + partial;
        end else if (neg_prod) begin
            product <= ~product + PW'(1);
        end
    end

endmodule

// File: tb/tb_mult_nxn_fast.sv
// Scoreboard bench for mult_nxn_fast: the driver queues hand-computed results,
// a monitor pops one per done pulse and checks product and busy length.
module tb_mult_nxn_fast;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        signed_mode = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy;
    logic        done;
    logic [63:0] product;

    typedef struct {
        logic [63:0] p;
        int          cyc;
        string       name;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sm;
        logic [63:0] p;
        int          cyc;
        string       name;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[11];
    int   checks = 0;
    int   errors = 0;
    int   busy_cnt = 0;
    logic prev_done = 1'b0;

    mult_nxn_fast #(.WIDTH(32), .CHUNK(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .signed_mode (signed_mode),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .product     (product)
    );

    always #5 clk = ~clk;

    task automatic check64(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Monitor: one scoreboard entry per done pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                busy_cnt  = 0;
                prev_done = 1'b0;
            end else begin
                if (busy) busy_cnt++;
                if (done) begin
                    checks++;
                    if (prev_done) begin
                        errors++;
                        $display("FAIL done_pulse_width actual=2+ required=1");
                    end
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done actual=done required=no_done product=%h", product);
                    end else begin
                        e = sb.pop_front();
                        check64({e.name, "_product"}, product, e.p);
                        checks++;
                        if (busy_cnt != e.cyc) begin
                            errors++;
                            $display("FAIL %s_busy_cycles actual=%0d required=%0d", e.name, busy_cnt, e.cyc);
                        end
                    end
                    busy_cnt = 0;
                end
                prev_done = done;
            end
        end
    end

    task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic sm,
                         input bit push, input logic [63:0] ep, input int ecyc, input string nm);
        exp_t e;
        a           = ia;
        b           = ib;
        signed_mode = sm;
        start       = 1'b1;
        if (push) begin
            e.p    = ep;
            e.cyc  = ecyc;
            e.name = nm;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        start       = 1'b0;
        a           = $urandom;
        b           = $urandom;
        signed_mode = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_done(input string nm);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            seen = done;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual=no_done required=done", nm);
        end
    endtask

    initial begin
        vecs[0]  = '{32'h12345678, 32'h9ABCDEF0, 1'b0, 64'h0B00EA4E242D2080, 17, "full_unsigned"};
        vecs[1]  = '{32'd5,        32'd7,        1'b0, 64'd35,                2,  "small_unsigned"};
        vecs[2]  = '{32'hFFFFFFFD, 32'd4,        1'b1, 64'hFFFFFFFFFFFFFFF4, 2,  "neg3x4_signed"};
        vecs[3]  = '{32'hFFFFFFFD, 32'd4,        1'b0, 64'h00000003FFFFFFF4, 5,  "neg3x4_unsigned"};
        vecs[4]  = '{32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000, 17, "minneg_sq"};
        vecs[5]  = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 64'h0000000080000000, 5,  "minneg_x_m1"};
        vecs[6]  = '{32'h00000000, 32'hDEADBEEF, 1'b0, 64'h0,                1,  "zero_a"};
        vecs[7]  = '{32'hFFFFFFFB, 32'hFFFFFFF9, 1'b1, 64'd35,               2,  "both_neg"};
        vecs[8]  = '{32'h00000100, 32'h00010000, 1'b0, 64'h0000000001000000, 7,  "mixed_digits"};
        vecs[9]  = '{32'd7,        32'hFFFFFF00, 1'b1, 64'hFFFFFFFFFFFFF900, 3,  "pos_x_neg"};
        vecs[10] = '{32'hDEADBEEF, 32'h00000000, 1'b1, 64'h0,                1,  "zero_b_neg"};

        repeat (2) @(posedge clk);
        @(negedge clk);
        check64("reset_busy", {63'd0, busy}, 64'd0);
        check64("reset_done", {63'd0, done}, 64'd0);
        check64("reset_product", product, 64'd0);
        reset = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].sm, 1'b1, vecs[i].p, vecs[i].cyc, vecs[i].name);
            wait_done(vecs[i].name);
            repeat (2) @(negedge clk);
            check64({vecs[i].name, "_hold"}, product, vecs[i].p);
        end

        // Start pulsed mid-job must be dropped, not queued.
        issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 64'hFFFFFFFE00000001, 17, "ignored_start_job");
        repeat (4) @(negedge clk);
        a = 32'd1;
        b = 32'd1;
        signed_mode = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("ignored_start_job");
        repeat (6) @(negedge clk);
        check64("ignored_start_hold", product, 64'hFFFFFFFE00000001);

        // Back-to-back: start accepted on the done cycle.
        issue(32'h00010000, 32'h00010000, 1'b0, 1'b1, 64'h0000000100000000, 10, "b2b_first");
        wait_done("b2b_first");
        issue(32'd3, 32'hFFFFFFFF, 1'b1, 1'b1, 64'hFFFFFFFFFFFFFFFD, 2, "b2b_second");
        check64("b2b_clear", product, 64'd0);
        wait_done("b2b_second");
        repeat (2) @(negedge clk);

        // Asynchronous reset mid-RUN aborts with no done pulse.
        issue(32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0, 64'd0, 0, "aborted");
        repeat (5) @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        check64("abort_busy", {63'd0, busy}, 64'd0);
        check64("abort_done", {63'd0, done}, 64'd0);
        check64("abort_product", product, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);

        issue(32'h0000FFFF, 32'h0000FFFF, 1'b0, 1'b1, 64'h00000000FFFE0001, 5, "post_reset");
        wait_done("post_reset");
        repeat (3) @(negedge clk);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
